alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter MUL_STAGES, default 2, number of internal multiply cycles (legal 1..4); used only when ALU_MUL_EN is defined.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ALUworkEn  input  1  issue strobe from ALU reservation station.
REQ-005 operandO, operandT  input  `DataBus  source operands.
REQ-006 wrtTag  input  `TagBus  destination tag of the issued op.
REQ-007 opCode  input  `OpBus  operation code.
REQ-008 instAddr  input  `InstAddrBus  PC of the issued instruction.
REQ-009 instBranchTag  input  `BranchTagBus  speculation mask of the issued op.
REQ-010 bFreeEn  input  1  branch at bFreeNum resolved.
REQ-011 bFreeNum  input  2  index of the resolved branch.
REQ-012 misTaken  input  1  resolved branch mispredicted; squash dependents.
REQ-013 enALUwrt  output  1  result broadcast valid.
REQ-014 ALUtag  output  `TagBus  tag of the broadcast result.
REQ-015 ALUdata  output  `DataBus  broadcast result value.
REQ-016 aluBusy  output  1  unit cannot accept an issue this cycle.

Function
REQ-017 Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (operandO op operandT); LUI = operandT; AUIPC = instAddr + operandT; JAL/JALR = instAddr + 4.
REQ-018 Arithmetic SHALL be 32-bit modulo 2^32; shift amount = operandT[4:0]; SLT signed, SLTU unsigned; result 1 or 0.
REQ-019 Single-cycle op issued in cycle N: enALUwrt=1 with ALUtag=wrtTag and ALUdata=result in cycle N+1, for exactly one cycle.
REQ-020 Cycles with no completing op: enALUwrt=0, ALUtag=`tagFree, ALUdata=`dataFree.
REQ-021 NOP or an unrecognised opCode SHALL complete as a single-cycle op with ALUdata=0.
REQ-022 FSM states IDLE and MUL. IDLE->MUL on accepted multiply issue; MUL->IDLE when the cycle counter reaches MUL_STAGES, or on squash.
REQ-023 aluBusy=1 exactly while in MUL; an issue with aluBusy=1 SHALL be ignored and change no state.
REQ-024 In-flight speculation mask: when bFreeEn=1 and mask bit bFreeNum is set, clear that bit in the same edge.
REQ-025 Squash: when misTaken=1 and in-flight mask bit bFreeNum is set, drop the op, suppress its broadcast, and return to IDLE.
REQ-026 Squash applies to an op issued in the same cycle (checked against instBranchTag) and to a registered single-cycle result not yet broadcast.
REQ-027 Squash takes priority over completion in the same cycle; the unit SHALL accept a new issue in the cycle after a squash.

Reset
REQ-028 With rst=1 at posedge: FSM=IDLE, counter=0, mask=0, enALUwrt=0, ALUtag=`tagFree, ALUdata=`dataFree, aluBusy=0.
REQ-029 Reset mid-multiply SHALL abandon the op with no broadcast; rst has priority over issue and squash.

Configuration
REQ-030 Macro ALU_MUL_EN defined: MUL, MULH, MULHSU, MULHU supported; issued in N, broadcast in N+MUL_STAGES+1 (low 32 bits for MUL, high 32 bits of the signed/mixed/unsigned 64-bit product otherwise).
REQ-031 ALU_MUL_EN undefined: no MUL state or multiplier, aluBusy tied 0, multiply opcodes handled as in REQ-021.

Verification
REQ-032 ADD 0x7FFFFFFF+1 tag 5 in cycle N -> N+1: enALUwrt=1, ALUtag=5, ALUdata=0x80000000; N+2: enALUwrt=0.
REQ-033 SRA 0x80000000 by 0x21 -> ALUdata=0xC0000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
REQ-034 JAL instAddr=0x100 -> ALUdata=0x104; AUIPC instAddr=0x100, operandT=0x1000 -> 0x1100.
REQ-035 ALU_MUL_EN, MUL_STAGES=2: MULHU 0xFFFFFFFF*0xFFFFFFFF in N -> aluBusy=1 for N+1..N+2; N+3 ALUdata=0xFFFFFFFE; ADD issued at N+1 produces no broadcast.
REQ-036 Multiply with mask 0b0100 in flight; bFreeNum=2, misTaken=1 -> no broadcast, aluBusy=0 next cycle. Repeat with misTaken=0, bFreeEn=1 -> mask 0, result broadcast on schedule.
REQ-037 rst asserted in N+1 of a multiply -> no broadcast, all outputs at reset values from N+2.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Issue / result-broadcast bundle between the ALU reservation station,
// the ALU execution unit and the common data bus.
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef TagBus
`define TagBus 4:0
`endif
`ifndef OpBus
`define OpBus 4:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef BranchTagBus
`define BranchTagBus 3:0
`endif
`ifndef tagFree
`define tagFree 5'b00000
`endif
`ifndef dataFree
`define dataFree 32'h0000_0000
`endif

interface alu_exec_unit_if;
  logic                 ALUworkEn;
  logic [`DataBus]      operandO;
  logic [`DataBus]      operandT;
  logic [`TagBus]       wrtTag;
  logic [`OpBus]        opCode;
  logic [`InstAddrBus]  instAddr;
  logic [`BranchTagBus] instBranchTag;
  logic                 bFreeEn;
  logic [1:0]           bFreeNum;
  logic                 misTaken;
  logic                 enALUwrt;
  logic [`TagBus]       ALUtag;
  logic [`DataBus]      ALUdata;
  logic                 aluBusy;

  modport master (
    output ALUworkEn, operandO, operandT, wrtTag, opCode, instAddr,
           instBranchTag, bFreeEn, bFreeNum, misTaken,
    input  enALUwrt, ALUtag, ALUdata, aluBusy
  );

  modport slave (
    input  ALUworkEn, operandO, operandT, wrtTag, opCode, instAddr,
           instBranchTag, bFreeEn, bFreeNum, misTaken,
    output enALUwrt, ALUtag, ALUdata, aluBusy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU ops with branch-speculation squash.
// Multi-cycle multiply (IDLE/MUL FSM) is built only when ALU_MUL_EN is defined.
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef TagBus
`define TagBus 4:0
`endif
`ifndef OpBus
`define OpBus 4:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef BranchTagBus
`define BranchTagBus 3:0
`endif
`ifndef tagFree
`define tagFree 5'b00000
`endif
`ifndef dataFree
`define dataFree 32'h0000_0000
`endif

module alu_exec_unit #(
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  localparam logic [`OpBus] OP_ADD   = 5'd1;
  localparam logic [`OpBus] OP_SUB   = 5'd2;
  localparam logic [`OpBus] OP_SLL   = 5'd3;
  localparam logic [`OpBus] OP_SLT   = 5'd4;
  localparam logic [`OpBus] OP_SLTU  = 5'd5;
  localparam logic [`OpBus] OP_XOR   = 5'd6;
  localparam logic [`OpBus] OP_SRL   = 5'd7;
  localparam logic [`OpBus] OP_SRA   = 5'd8;
  localparam logic [`OpBus] OP_OR    = 5'd9;
  localparam logic [`OpBus] OP_AND   = 5'd10;
  localparam logic [`OpBus] OP_LUI   = 5'd11;
  localparam logic [`OpBus] OP_AUIPC = 5'd12;
  localparam logic [`OpBus] OP_JAL   = 5'd13;
  localparam logic [`OpBus] OP_JALR  = 5'd14;

  localparam logic [`BranchTagBus] MASK_BIT0 = 4'b0001;

  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_stage_chk
    $error("alu_exec_unit: MUL_STAGES must be within 1..4");
  end

  logic                 busy;
  logic                 is_mul_op;
  logic                 mul_done;
  logic [`TagBus]       mul_tag;
  logic [`DataBus]      mul_res;

  logic                 issue_ok;
  logic                 issue_sq;
  logic                 inflight_sq;
  logic                 bcast;
  logic [`BranchTagBus] clr_mask;
  logic [4:0]           sh;
  logic [`DataBus]      alu_res;

  logic [`BranchTagBus] mask_q, mask_d;
  logic                 res_vld_q, res_vld_d;
  logic [`TagBus]       res_tag_q, res_tag_d;
  logic [`DataBus]      res_data_q, res_data_d;

  assign issue_ok    = bus.ALUworkEn && !busy;
  assign issue_sq    = bus.misTaken && bus.instBranchTag[bus.bFreeNum];
  assign inflight_sq = bus.misTaken && mask_q[bus.bFreeNum];
  assign clr_mask    = bus.bFreeEn ? ~(MASK_BIT0 << bus.bFreeNum) : '1;
  assign sh          = bus.operandT[4:0];

  always_comb begin
    alu_res = '0;
    case (bus.opCode)
      OP_ADD:   alu_res = bus.operandO + bus.operandT;
      OP_SUB:   alu_res = bus.operandO - bus.operandT;
      OP_SLL:   alu_res = bus.operandO << sh;
      OP_SLT:   alu_res = {31'd0, $signed(bus.operandO) < $signed(bus.operandT)};
      OP_SLTU:  alu_res = {31'd0, bus.operandO < bus.operandT};
      OP_XOR:   alu_res = bus.operandO ^ bus.operandT;
      OP_SRL:   alu_res = bus.operandO >> sh;
      OP_SRA:   alu_res = $signed(bus.operandO) >>> sh;
      OP_OR:    alu_res = bus.operandO | bus.operandT;
      OP_AND:   alu_res = bus.operandO & bus.operandT;
      OP_LUI:   alu_res = bus.operandT;
      OP_AUIPC: alu_res = bus.instAddr + bus.operandT;
      OP_JAL,
      OP_JALR:  alu_res = bus.instAddr + 32'd4;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  // state | meaning
  // IDLE  | accepting issues; single-cycle results go straight to the result reg
  // MUL   | multiply in flight, issues refused until the counter hits MUL_STAGES
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [`OpBus] OP_MUL    = 5'd15;
  localparam logic [`OpBus] OP_MULH   = 5'd16;
  localparam logic [`OpBus] OP_MULHSU = 5'd17;
  localparam logic [`OpBus] OP_MULHU  = 5'd18;
  localparam logic [2:0]    STAGES    = 3'(MUL_STAGES);

  logic [0:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [`DataBus]     mul_a_q, mul_b_q;
  logic [1:0]          mul_kind_q;
  logic [`TagBus]      mul_tag_q;
  logic [32:0]         mul_a_x, mul_b_x;
  logic signed [63:0]  mul_prod;

  assign is_mul_op = (bus.opCode == OP_MUL) || (bus.opCode == OP_MULH) ||
                     (bus.opCode == OP_MULHSU) || (bus.opCode == OP_MULHU);
  assign busy      = (state_q == ST_MUL);
  assign mul_done  = busy && ((cnt_q + 3'd1) == STAGES);
  assign mul_tag   = mul_tag_q;

  // kind 1 = MULH (both signed), 2 = MULHSU (only rs1 signed), 0/3 unsigned
  assign mul_a_x  = {mul_a_q[31] & ((mul_kind_q == 2'd1) || (mul_kind_q == 2'd2)), mul_a_q};
  assign mul_b_x  = {mul_b_q[31] & (mul_kind_q == 2'd1), mul_b_q};
  assign mul_prod = $signed({{31{mul_a_x[32]}}, mul_a_x}) * $signed({{31{mul_b_x[32]}}, mul_b_x});
  assign mul_res  = (mul_kind_q == 2'd0) ? mul_prod[31:0] : mul_prod[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (busy) begin
      if (inflight_sq || mul_done) begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (issue_ok && is_mul_op && !issue_sq) begin
      state_d = ST_MUL;
      cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_ok && is_mul_op) begin
      mul_a_q    <= bus.operandO;
      mul_b_q    <= bus.operandT;
      mul_kind_q <= 2'(bus.opCode - OP_MUL);
      mul_tag_q  <= bus.wrtTag;
    end
  end
`else
  assign is_mul_op = 1'b0;
  assign busy      = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_tag   = `tagFree;
  assign mul_res   = `dataFree;
`endif

  // mask_q follows whichever op is in flight: the multiply, or the result awaiting broadcast
  always_comb begin
    mask_d     = '0;
    res_vld_d  = 1'b0;
    res_tag_d  = `tagFree;
    res_data_d = `dataFree;
    if (busy) begin
      if (!inflight_sq) begin
        mask_d = mask_q & clr_mask;
        if (mul_done) begin
          res_vld_d  = 1'b1;
          res_tag_d  = mul_tag;
          res_data_d = mul_res;
        end
      end
    end else if (issue_ok && !issue_sq) begin
      mask_d = bus.instBranchTag & clr_mask;
      if (!is_mul_op) begin
        res_vld_d  = 1'b1;
        res_tag_d  = bus.wrtTag;
        res_data_d = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      res_vld_q  <= 1'b0;
      res_tag_q  <= `tagFree;
      res_data_q <= `dataFree;
    end else begin
      mask_q     <= mask_d;
      res_vld_q  <= res_vld_d;
      res_tag_q  <= res_tag_d;
      res_data_q <= res_data_d;
    end
  end

  // a mispredict arriving in the broadcast cycle still kills the result
  assign bcast        = res_vld_q && !inflight_sq;
  assign bus.enALUwrt = bcast;
  assign bus.ALUtag   = bcast ? res_tag_q : `tagFree;
  assign bus.ALUdata  = bcast ? res_data_q : `dataFree;
  assign bus.aluBusy  = busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed spec vectors plus random
// traffic checked against a cycle-indexed queue model of issued ops.
module tb_alu_exec_unit;
  localparam int S = 2;
  localparam logic [4:0]  TAG_FREE  = 5'd0;
  localparam logic [31:0] DATA_FREE = 32'd0;
  localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_SLL = 5'd3,
    OP_SLT = 5'd4, OP_SLTU = 5'd5, OP_XOR = 5'd6, OP_SRL = 5'd7, OP_SRA = 5'd8,
    OP_OR = 5'd9, OP_AND = 5'd10, OP_LUI = 5'd11, OP_AUIPC = 5'd12, OP_JAL = 5'd13,
    OP_JALR = 5'd14, OP_MUL = 5'd15, OP_MULH = 5'd16, OP_MULHSU = 5'd17, OP_MULHU = 5'd18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if bus();
  alu_exec_unit #(.MUL_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  typedef struct {
    int          issue;
    int          due;
    bit          is_mul;
    logic [4:0]  tag;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;
  ent_t pend[$];

  logic        exp_en, exp_busy, obs_en, obs_busy;
  logic [4:0]  exp_tag, obs_tag;
  logic [31:0] exp_data, obs_data;

  function automatic bit is_mul(input logic [4:0] op);
`ifdef ALU_MUL_EN
    return (op >= OP_MUL) && (op <= OP_MULHU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    int     s  = int'(b % 32);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SLL:   return a << s;
      OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:  return (ua < ub) ? 32'd1 : 32'd0;
      OP_XOR:   return a ^ b;
      OP_SRL:   return a >> s;
      OP_SRA:   return 32'(sa >> s);
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_LUI:   return b;
      OP_AUIPC: return pc + b;
      OP_JAL, OP_JALR: return pc + 32'd4;
`ifdef ALU_MUL_EN
      OP_MUL:    return 32'(ua * ub);
      OP_MULH:   return 32'((sa * sb) >> 32);
      OP_MULHSU: return 32'((sa * ub) >> 32);
      OP_MULHU:  return 32'((ua * ub) >> 32);
`endif
      default:  return 32'd0;
    endcase
  endfunction

  // expectation for the current cycle, then advance the model past the edge
  function automatic void model_cycle();
    logic [3:0] clr;
    ent_t keep[$];
    exp_en = 1'b0; exp_tag = TAG_FREE; exp_data = DATA_FREE; exp_busy = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].is_mul && cyc_n > pend[i].issue && cyc_n <= pend[i].issue + S) exp_busy = 1'b1;
      if (pend[i].due == cyc_n && !(bus.misTaken && pend[i].mask[bus.bFreeNum])) begin
        exp_en = 1'b1; exp_tag = pend[i].tag; exp_data = pend[i].data;
      end
    end
    if (rst) begin
      pend.delete();
      return;
    end
    clr = 4'hF;
    if (bus.bFreeEn) clr[bus.bFreeNum] = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due != cyc_n && !(bus.misTaken && pend[i].mask[bus.bFreeNum])) begin
        ent_t e = pend[i];
        e.mask = e.mask & clr;
        keep.push_back(e);
      end
    end
    pend = keep;
    if (bus.ALUworkEn && !exp_busy && !(bus.misTaken && bus.instBranchTag[bus.bFreeNum])) begin
      ent_t e;
      e.issue  = cyc_n;
      e.is_mul = is_mul(bus.opCode);
      e.due    = cyc_n + (e.is_mul ? S + 1 : 1);
      e.tag    = bus.wrtTag;
      e.data   = ref_alu(bus.opCode, bus.operandO, bus.operandT, bus.instAddr);
      e.mask   = bus.instBranchTag & clr;
      pend.push_back(e);
    end
  endfunction

  task automatic cyc(input logic r, input logic iss, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tg, input logic [31:0] pc,
                     input logic [3:0] bt, input logic fe, input logic [1:0] fn, input logic mis);
    rst = r; bus.ALUworkEn = iss; bus.opCode = op; bus.operandO = a; bus.operandT = b;
    bus.wrtTag = tg; bus.instAddr = pc; bus.instBranchTag = bt;
    bus.bFreeEn = fe; bus.bFreeNum = fn; bus.misTaken = mis;
    @(negedge clk);
    obs_en = bus.enALUwrt; obs_tag = bus.ALUtag; obs_data = bus.ALUdata; obs_busy = bus.aluBusy;
    model_cycle();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] pc, input logic [3:0] bt);
    cyc(1'b0, 1'b1, op, a, b, tg, pc, bt, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b0, 2'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    cyc(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, OP_ADD, 32'd1, 32'd2, 5'd3, 32'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    total++;
    if ({obs_en, obs_tag, obs_data, obs_busy} !== {1'b0, TAG_FREE, DATA_FREE, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got en=%b tag=%0d data=%h busy=%b, want 0/%0d/%h/0",
               obs_en, obs_tag, obs_data, obs_busy, TAG_FREE, DATA_FREE);
    end
    idle();
    total++;
    if (obs_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_ignores_issue: got en=%b, want 0", obs_en);
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops [6] = '{OP_ADD, OP_SRA, OP_SLTU, OP_SLT, OP_JAL, OP_AUIPC};
    logic [31:0] av  [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd1, 32'd0, 32'd0};
    logic [31:0] bv  [6] = '{32'd1, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h1000};
    logic [31:0] pcv [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h100, 32'h100};
    logic [31:0] want[6] = '{32'h8000_0000, 32'hC000_0000, 32'd1, 32'd0, 32'h104, 32'h1100};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) issue(ops[i], av[i], bv[i], 5'(i + 5), pcv[i], 4'd0);
      else idle();
      if (i > 0) begin
        total++;
        if ({obs_en, obs_tag, obs_data} !== {1'b1, 5'(i + 4), want[i-1]}) begin
          bad++;
          $display("FAIL directed_%0d: got en=%b tag=%0d data=%h, want 1/%0d/%h",
                   i - 1, obs_en, obs_tag, obs_data, i + 4, want[i-1]);
        end
      end
    end
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data} !== {1'b0, TAG_FREE, DATA_FREE}) begin
      bad++;
      $display("FAIL directed_quiet: got en=%b tag=%0d data=%h, want idle", obs_en, obs_tag, obs_data);
    end
  endtask

  task automatic test_squash_single();
    issue(OP_ADD, 32'd10, 32'd20, 5'd11, 32'd0, 4'b0010);
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b1, 2'd1, 1'b1);
    total++;
    if (obs_en !== 1'b0) begin
      bad++;
      $display("FAIL squash_pending: got en=%b, want 0", obs_en);
    end
    cyc(1'b0, 1'b1, OP_OR, 32'd1, 32'd2, 5'd12, 32'd0, 4'b0100, 1'b1, 2'd2, 1'b1);
    idle();
    total++;
    if (obs_en !== 1'b0) begin
      bad++;
      $display("FAIL squash_same_cycle: got en=%b, want 0", obs_en);
    end
    issue(OP_SUB, 32'd5, 32'd7, 5'd13, 32'd0, 4'b0010);
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b1, 2'd0, 1'b1);
    total++;
    if ({obs_en, obs_tag, obs_data} !== {1'b1, 5'd13, 32'hFFFF_FFFE}) begin
      bad++;
      $display("FAIL squash_other_branch: got en=%b tag=%0d data=%h, want 1/13/fffffffe",
               obs_en, obs_tag, obs_data);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd0, 4'd0);
    issue(OP_ADD, 32'd1, 32'd1, 5'd9, 32'd0, 4'd0);
    total++;
    if (obs_busy !== 1'b1) begin bad++; $display("FAIL mul_busy_n1: got %b, want 1", obs_busy); end
    idle();
    total++;
    if ({obs_busy, obs_en} !== 2'b10) begin
      bad++; $display("FAIL mul_busy_n2: got busy=%b en=%b, want 1/0", obs_busy, obs_en);
    end
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data, obs_busy} !== {1'b1, 5'd7, 32'hFFFF_FFFE, 1'b0}) begin
      bad++;
      $display("FAIL mulhu_result: got en=%b tag=%0d data=%h busy=%b, want 1/7/fffffffe/0",
               obs_en, obs_tag, obs_data, obs_busy);
    end
    idle();
    total++;
    if (obs_en !== 1'b0) begin bad++; $display("FAIL mul_ignored_add: got en=%b, want 0", obs_en); end

    issue(OP_MUL, 32'd6, 32'd7, 5'd3, 32'd0, 4'b0100);
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b1, 2'd2, 1'b1);
    issue(OP_XOR, 32'hF0, 32'h0F, 5'd4, 32'd0, 4'd0);
    total++;
    if (obs_busy !== 1'b0) begin bad++; $display("FAIL squash_frees_unit: got busy=%b, want 0", obs_busy); end
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data} !== {1'b1, 5'd4, 32'hFF}) begin
      bad++;
      $display("FAIL issue_after_squash: got en=%b tag=%0d data=%h, want 1/4/ff", obs_en, obs_tag, obs_data);
    end

    issue(OP_MUL, 32'd3, 32'd5, 5'd3, 32'd0, 4'b0100);
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b1, 2'd2, 1'b0);
    cyc(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b1, 2'd2, 1'b1);
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data} !== {1'b1, 5'd3, 32'd15}) begin
      bad++;
      $display("FAIL mul_after_free: got en=%b tag=%0d data=%h, want 1/3/f", obs_en, obs_tag, obs_data);
    end

    issue(OP_MULH, 32'h8000_0000, 32'd2, 5'd8, 32'd0, 4'd0);
    cyc(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data, obs_busy} !== {1'b0, TAG_FREE, DATA_FREE, 1'b0}) begin
      bad++;
      $display("FAIL mul_reset: got en=%b tag=%0d data=%h busy=%b, want idle", obs_en, obs_tag, obs_data, obs_busy);
    end
    idle();
    total++;
    if (obs_en !== 1'b0) begin bad++; $display("FAIL mul_reset_late: got en=%b, want 0", obs_en); end
  endtask
`else
  task automatic test_mul();
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd0, 4'd0);
    idle();
    total++;
    if ({obs_en, obs_tag, obs_data, obs_busy} !== {1'b1, 5'd7, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL mul_disabled: got en=%b tag=%0d data=%h busy=%b, want 1/7/0/0",
               obs_en, obs_tag, obs_data, obs_busy);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 23)),
          rand_word(), rand_word(), 5'($urandom_range(1, 31)), $urandom,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
          ($urandom_range(0, 7) == 0), 2'($urandom), ($urandom_range(0, 9) == 0));
      total++;
      if ({obs_en, obs_tag, obs_data, obs_busy} !== {exp_en, exp_tag, exp_data, exp_busy}) begin
        bad++;
        $display("FAIL random_cycle_%0d: got en=%b tag=%0d data=%h busy=%b, want %b/%0d/%h/%b",
                 cyc_n - 1, obs_en, obs_tag, obs_data, obs_busy, exp_en, exp_tag, exp_data, exp_busy);
      end
    end
  endtask

  initial begin
    bus.ALUworkEn = 1'b0; bus.opCode = OP_NOP; bus.operandO = '0; bus.operandT = '0;
    bus.wrtTag = '0; bus.instAddr = '0; bus.instBranchTag = '0;
    bus.bFreeEn = 1'b0; bus.bFreeNum = '0; bus.misTaken = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_squash_single();
    test_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
